// File: rtl/imm_arith_exec.sv
// RV32I OP-IMM execute stage with a single registered writeback slot.
// Optional IMM_ARITH_EXEC_ILLEGAL_TRAP_EN turns iak_invalid into a trapping entry.
package imm_arith_pkg;
  typedef enum logic [3:0] {
    iak_invalid,
    iak_addi,
    iak_slti,
    iak_sltiu,
    iak_xori,
    iak_ori,
    iak_andi,
    iak_slli,
    iak_srli,
    iak_srai
  } imm_arith_kind_t;
endpackage

module imm_arith_exec
  import imm_arith_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  imm_arith_kind_t in_kind,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [11:0]     in_imm,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  output logic [CNT_W-1:0] retired
);

  logic [XLEN-1:0]        simm;
  logic [4:0]             shamt;
  logic signed [XLEN-1:0] rs1_s;
  logic [XLEN-1:0]        result_d;
  logic                   is_invalid;
  logic                   accept;
  logic                   load;
  logic                   handoff;

  logic                   valid_q;
  logic [XLEN-1:0]        result_q;
  logic [4:0]             rd_q;
  logic                   we_q;
  logic [CNT_W-1:0]       retired_q;

  assign simm       = {{(XLEN-12){in_imm[11]}}, in_imm};
  assign shamt      = in_imm[4:0];
  assign rs1_s      = in_rs1;
  assign is_invalid = (in_kind == iak_invalid);

  always_comb begin
    result_d = '0;
    unique case (in_kind)
      iak_addi:  result_d = in_rs1 + simm;
      iak_slti:  result_d = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(simm))};
      iak_sltiu: result_d = {{(XLEN-1){1'b0}}, (in_rs1 < simm)};
      iak_xori:  result_d = in_rs1 ^ simm;
      iak_ori:   result_d = in_rs1 | simm;
      iak_andi:  result_d = in_rs1 & simm;
      iak_slli:  result_d = in_rs1 << shamt;
      iak_srli:  result_d = in_rs1 >> shamt;
      iak_srai:  result_d = rs1_s >>> shamt;
      default:   result_d = '0;
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // A flushed handoff never reaches writeback, so it is not counted.
  assign handoff  = valid_q && out_ready && !flush;

`ifdef IMM_ARITH_EXEC_ILLEGAL_TRAP_EN
  logic illegal_q;

  assign load        = accept;
  assign out_illegal = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (load) begin
      illegal_q <= is_invalid;
    end
  end
`else
  // Invalid kinds are consumed without producing an entry.
  assign load        = accept && !is_invalid;
  assign out_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      if (handoff) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q  <= 1'b1;
        result_q <= result_d;
        rd_q     <= in_rd;
        we_q     <= (in_rd != 5'd0) && !is_invalid;
      end else if (handoff) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_we     = we_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_imm_arith_exec.sv
// Randomized bench for imm_arith_exec against a behavioural model, plus directed literal checks.
module tb_imm_arith_exec;
  import imm_arith_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  imm_arith_kind_t in_kind;
  logic [31:0]     in_rs1;
  logic [11:0]     in_imm;
  logic [4:0]      in_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;
  logic [31:0]     retired;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_valid;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  bit          m_we;
  bit          m_ill;
  logic [31:0] m_retired;

`ifdef IMM_ARITH_EXEC_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  imm_arith_exec #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs1(in_rs1), .in_imm(in_imm), .in_rd(in_rd), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_illegal(out_illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(imm_arith_kind_t k, logic [31:0] a, logic [11:0] im);
    logic [31:0] s;
    int unsigned sh;
    longint sa, sb;
    s  = {{20{im[11]}}, im};
    sh = im[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(s));
    case (k)
      iak_addi:  return 32'((64'(a) + 64'(s)) % 64'h1_0000_0000);
      iak_slti:  return (sa < sb) ? 32'd1 : 32'd0;
      iak_sltiu: return (64'(a) < 64'(s)) ? 32'd1 : 32'd0;
      iak_xori:  return a ^ s;
      iak_ori:   return a | s;
      iak_andi:  return a & s;
      iak_slli:  return 32'(64'(a) * (64'd1 << sh));
      iak_srli:  return 32'(64'(a) / (64'd1 << sh));
      iak_srai:  return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      default:   return 32'd0;
    endcase
  endfunction

  // Behavioural model, advanced on each rising edge from the inputs presented.
  always @(posedge clk) begin
    bit rdy, acc, ho, takes;
    if (rst) begin
      m_valid = 0; m_result = 0; m_rd = 0; m_we = 0; m_ill = 0; m_retired = 0;
    end else begin
      rdy   = !m_valid || out_ready;
      acc   = in_valid && rdy && !flush;
      ho    = m_valid && out_ready && !flush;
      takes = acc && (in_kind != iak_invalid || TrapEn);
      if (ho) m_retired = m_retired + 1;
      if (flush) m_valid = 0;
      else if (takes) begin
        m_valid  = 1;
        m_result = ref_result(in_kind, in_rs1, in_imm);
        m_rd     = in_rd;
        m_ill    = (in_kind == iak_invalid);
        m_we     = (in_rd != 0) && !m_ill;
      end else if (ho) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("out_result", out_result, m_result);
      check("out_rd", 32'(out_rd), 32'(m_rd));
      check("out_we", 32'(out_we), 32'(m_we));
      check("out_illegal", 32'(out_illegal), 32'(m_ill));
      check("retired", retired, m_retired);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    step();
    rst = 0;
  endtask

  // Present one request with backpressure so the result stays parked for inspection.
  task automatic send_hold(input imm_arith_kind_t k, input logic [31:0] a, input logic [11:0] im,
                           input logic [4:0] rd);
    out_ready = 0; in_valid = 1; in_kind = k; in_rs1 = a; in_imm = im; in_rd = rd;
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  initial begin
    in_kind = iak_addi; in_rs1 = 0; in_imm = 0; in_rd = 0;
    do_reset();
    chk_en = 1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_retired", retired, 32'd0);

    send_hold(iak_addi, 32'h5, 12'hFFF, 5'd3);
    check("addi_res", out_result, 32'h4);
    check("addi_we", 32'(out_we), 32'd1);
    drain();
    check("addi_retired", retired, 32'd1);

    send_hold(iak_sltiu, 32'h1, 12'hFFF, 5'd4);
    check("sltiu", out_result, 32'd1);
    drain();
    send_hold(iak_slti, 32'h1, 12'hFFF, 5'd4);
    check("slti", out_result, 32'd0);
    drain();
    send_hold(iak_srai, 32'h8000_0000, 12'h004, 5'd6);
    check("srai", out_result, 32'hF800_0000);
    drain();
    send_hold(iak_srli, 32'h8000_0000, 12'h004, 5'd6);
    check("srli", out_result, 32'h0800_0000);
    drain();
    send_hold(iak_slli, 32'h1, 12'h01F, 5'd6);
    check("slli", out_result, 32'h8000_0000);
    drain();
    send_hold(iak_addi, 32'h7, 12'h001, 5'd0);
    check("rd0_we", 32'(out_we), 32'd0);
    drain();
    send_hold(iak_invalid, 32'h7, 12'h001, 5'd5);
    if (TrapEn) begin
      check("inv_valid", 32'(out_valid), 32'd1);
      check("inv_ill", 32'(out_illegal), 32'd1);
      check("inv_we", 32'(out_we), 32'd0);
    end else begin
      check("inv_valid", 32'(out_valid), 32'd0);
    end
    drain();

    // Backpressure: three ori ops, sink stalled for two cycles.
    do_reset();
    send_hold(iak_ori, 32'h0, 12'h0F0, 5'd1);
    in_valid = 1; in_kind = iak_ori; in_rs1 = 32'h100; in_imm = 12'h00F; in_rd = 5'd2;
    check("bp_ready0", 32'(in_ready), 32'd0);
    check("bp_hold0", out_result, 32'hF0);
    step();
    check("bp_hold1", out_result, 32'hF0);
    out_ready = 1;
    step();
    check("bp_second", out_result, 32'h10F);
    in_rs1 = 32'h2000; in_imm = 12'h001; in_rd = 5'd3;
    step();
    check("bp_third", out_result, 32'h2001);
    in_valid = 0;
    step();
    check("bp_retired", retired, 32'd3);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush with a held entry, handoff and a new request all in the same cycle.
    send_hold(iak_addi, 32'h10, 12'h010, 5'd7);
    out_ready = 1; flush = 1; in_valid = 1;
    step();
    flush = 0; in_valid = 0; out_ready = 0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_retired", retired, 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_kind   = imm_arith_kind_t'($urandom_range(0, 9));
      in_rs1    = $urandom();
      if ($urandom_range(0, 3) == 0) in_rs1 = {$urandom_range(0, 1) == 1, 31'h0};
      in_imm    = 12'($urandom());
      in_rd     = 5'($urandom_range(0, 31));
      step();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_arith_exec.md
# imm_arith_exec

Execute stage for RV32I register-immediate arithmetic (OP-IMM). Consumes the `imm_arith_kind_t` produced by the immediate-arithmetic decoder together with the rs1 operand, the 12-bit immediate and the destination register index. Produces a registered 32-bit writeback result through a valid/ready handshake. Sits between decode/operand-read and the writeback stage.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `in_valid` input 1: request carries an instruction.
- `in_ready` output 1: stage accepts the request this cycle.
- `in_kind` input `imm_arith_kind_t`: operation, from `opcode_type`.
- `in_rs1` input XLEN: rs1 operand value.
- `in_imm` input 12: raw I-type immediate `instr[31:20]`.
- `in_rd` input 5: destination register index.
- `flush` input 1: discard the held result and any request presented this cycle.
- `out_valid` output 1: result available.
- `out_ready` input 1: writeback consumes the result.
- `out_result` output XLEN: computed value.
- `out_rd` output 5: destination index.
- `out_we` output 1: write enable; 0 when `out_rd`==0.
- `out_illegal` output 1: entry came from `iak_invalid`. Only active under the configuration macro.
- `retired` output CNT_W: count of results handed off to writeback.

## Operation
- Immediate: `simm = sign-extend(in_imm)` to 32 bits. Shift amount: `shamt = in_imm[4:0]`.
- Kind to result:
  - addi: `rs1+simm` mod 2^32.
  - slti: `$signed(rs1) < $signed(simm)` gives 1, else 0.
  - sltiu: `rs1 < simm`, unsigned; `simm` is still the sign-extended value.
  - xori, ori, andi: bitwise operation with `simm`.
  - slli: `rs1<<shamt`.
  - srli: logical right shift.
  - srai: arithmetic right shift.
- Single output register holding one entry: `{result, rd, we, illegal}` plus the valid bit `out_valid`.
- `in_ready = !out_valid || out_ready`. The stage is combinationally transparent to backpressure.
- Accept when `in_valid && in_ready && !flush`: load the register and set `out_valid=1`.
- Handoff when `out_valid && out_ready`: if no new accept, clear `out_valid`. `retired` increments by 1 and wraps at 2^CNT_W.
- Simultaneous handoff and accept: the register reloads, `out_valid` stays 1, and `retired` still increments.
- `flush`:
  - Clears `out_valid` next cycle and ignores `in_valid`.
  - Takes priority over accept.
  - If `out_ready` is also high, the handoff is not counted.
- Outputs are held stable while `out_valid && !out_ready`.

## Timing
- Latency: 1 cycle. A request accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 per cycle while `out_ready` stays high.
- Reset, on the edge with `rst`=1:
  - `out_valid=0`, `out_result=0`, `out_rd=0`, `out_we=0`, `out_illegal=0`, `retired=0`.
  - `in_ready` reads 1 combinationally after reset (output register empty).
- Reset during a stalled entry drops that entry; it is not counted.
- Reset has priority over `flush` and handshakes.
- No state machine beyond the valid bit: EMPTY (`out_valid=0`) and FULL (`out_valid=1`). Transitions are as described above.

## Configuration
- Macro: `IMM_ARITH_EXEC_ILLEGAL_TRAP_EN`.
- Defined:
  - `iak_invalid` is accepted as an entry with `out_illegal=1`, `out_we=0`, `out_result=0`.
  - The entry handshakes and counts like any other.
- Undefined:
  - `iak_invalid` is accepted and silently dropped: no entry, `out_valid` is not set, no count.
  - If a handoff happens in the same cycle, `out_valid` clears.
  - `out_illegal` is tied to 0.

## Test plan
- Reset then single addi: `rs1=0x0000_0005`, `imm=0xFFF` -> 1 cycle later `out_result=0x0000_0004`, `out_we=1`, `retired=1` after handoff.
- sltiu edge: `rs1=0x0000_0001`, `imm=0xFFF` -> `out_result=1` (1 < 0xFFFF_FFFF). slti with the same inputs -> 0.
- Shifts: `rs1=0x8000_0000`, srai with shamt 4 -> `0xF800_0000`. srli with shamt 4 -> `0x0800_0000`. slli with shamt 31 on `rs1=1` -> `0x8000_0000`.
- Backpressure: stream of 3 ori ops with `out_ready=0` for 2 cycles.
  - `in_ready=0` while full and the first result is held stable.
  - Releasing `out_ready` drains all 3 in order at 1 per cycle; `retired=3`.
- Flush with `out_valid=1`, `out_ready=1`, `in_valid=1` -> next cycle `out_valid=0`, `retired` unchanged, new request discarded.
- `iak_invalid` with `rd=5`:
  - Macro defined -> `out_valid=1`, `out_illegal=1`, `out_we=0`.
  - Macro undefined -> `out_valid` stays 0.
  - Also `rd=0` addi -> `out_we=0`.
